i2c_od_bridge: RTL and testbench
================================

# i2c_od_bridge

Parametrised, multi-line, bidirectional open-drain bridge. Each of NUM_LINES lines (typically SCL and SDA of one or more buses) connects pad A to pad B. Whichever side is externally pulled low first owns the line, and the block pulls the other side low for as long as the owner holds it. Each line has input synchronisation, glitch filtering, a configurable dead time and a stuck-low timeout. The block sits between FPGA pin groups, for example a header bus and an on-board peripheral bus.

## Interface
- NUM_LINES, 2, number of independent bridged lines
- SYNC_STAGES, 2, synchroniser flops per pad input (≥2)
- FILTER_CYCLES, 3, consecutive equal samples needed to accept a level; 0 = filter bypassed
- DEAD_CYCLES, 16, cycles a line ignores both pads after ownership ends (≥1)
- TIMEOUT_CYCLES, 0, maximum cycles in an owned state before the line is declared stuck; 0 = timeout disabled
- iCLK  in  1  single system clock
- iRST  in  1  synchronous, active-high reset
- iENABLE  in  NUM_LINES  per-line enable; 0 forces the line idle and never driven
- bPORT_A  inout  NUM_LINES  side-A pads; driven only to 0 or Z
- bPORT_B  inout  NUM_LINES  side-B pads; driven only to 0 or Z
- oOWNER_A  out  NUM_LINES  line is in A_OWNS (side B driven low)
- oOWNER_B  out  NUM_LINES  line is in B_OWNS (side A driven low)
- oSTUCK  out  NUM_LINES  line is in STUCK

## Operation
- Per line, the pad value read back (readback) passes through a SYNC_STAGES synchroniser and then the filter. The filtered level changes only after FILTER_CYCLES consecutive samples of the new level.
- States: IDLE, A_OWNS, B_OWNS, DEAD, STUCK.
- IDLE:
  - filtered A = 0 and B = 1 → A_OWNS.
  - filtered B = 0 and A = 1 → B_OWNS.
  - both 0 → remain IDLE; no drive, so there is no contention.
- A_OWNS: pad B output enable = 1, driving 0. Filtered B is ignored.
  - filtered A = 1 → DEAD.
  - timer reaches TIMEOUT_CYCLES (if nonzero) → STUCK.
- B_OWNS: mirror of A_OWNS.
- DEAD: no drive. Counts DEAD_CYCLES, then → IDLE. This suppresses the echo of the side just released.
- STUCK: no drive. Leaves → DEAD when filtered A = 1 and filtered B = 1.
- iENABLE[i] = 0: state → IDLE and counters cleared on the next edge, overriding all other transitions. Filter and synchroniser keep running.
- Drive decode: pad output enables and oOWNER_*/oSTUCK are decoded combinationally from the state register, so they are glitch-free and registered-equivalent.
- Counters:
  - Width $clog2(max+1) of their respective limit.
  - Saturating; never wrap.
  - Ownership timer cleared on entry to A_OWNS/B_OWNS.
  - Dead counter cleared on entry to DEAD.
- Reset state: all lines IDLE, synchroniser and filter outputs = 1, counters = 0, all pads Z, all status outputs = 0.

## Timing
- Pad fall to opposite-side drive: SYNC_STAGES + FILTER_CYCLES + 1 rising edges (6 with defaults; SYNC_STAGES + 1 with the filter bypassed).
- Owner release to opposite-side release: the same latency.
- Line idle after release: DEAD_CYCLES edges after entering DEAD.
- Timeout: STUCK is entered on the edge on which the timer equals TIMEOUT_CYCLES. The drive drops on that edge.
- Reset mid-operation: drive released and outputs cleared one edge after iRST is sampled high. No drive while iRST = 1.
- Lines are fully independent. Simultaneous events on different lines do not interact.

## Structure
- Package i2c_od_bridge_pkg: state enum (IDLE, A_OWNS, B_OWNS, DEAD, STUCK) and a counter-width helper function.
- Sub-module od_line_channel: one line's synchroniser, filter, FSM and counters. It produces drive-A/drive-B enables.
- Top: generate loop over NUM_LINES instantiating od_line_channel. The tristate assigns (0 when enabled, else Z) live at the top.

## Test plan
- Defaults, A pulled low for 40 cycles then released:
  - B driven low 6 edges after the fall; oOWNER_A = 1.
  - B released 6 edges after A rises.
  - DEAD lasts 16 edges; B's slow rise never causes B_OWNS.
- FILTER_CYCLES = 3, 2-cycle low pulse on A → no drive, state stays IDLE.
- A and B pulled low on the same edge from IDLE → no drive. Then A released while B is held → B_OWNS after 6 edges, and A is driven low.
- TIMEOUT_CYCLES = 100, A held low for 300 cycles:
  - B released on the 100th A_OWNS edge; oSTUCK = 1.
  - After A is released: DEAD, then IDLE; oSTUCK = 0.
- iRST asserted for 1 cycle during A_OWNS → B is Z and all outputs are 0 on the next edge, with the filters reset to 1.
- NUM_LINES = 2, line 0 A-owned while line 1 is B-owned concurrently → independent drives. Then iENABLE[1] = 0 → line 1 is released the next edge and line 0 is unaffected.

Source files
------------

// File: rtl/i2c_od_bridge_pkg.sv
// i2c_od_bridge_pkg: line state encoding and counter sizing shared by the open-drain bridge.
package i2c_od_bridge_pkg;
    typedef enum logic [2:0] {IDLE, A_OWNS, B_OWNS, DEAD, STUCK} lineState_t;
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction
endpackage

// File: rtl/od_line_channel.sv
// od_line_channel: one bridged line -- pad synchronisers, glitch filters, ownership FSM and counters.
module od_line_channel
    import i2c_od_bridge_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 3,
    parameter int DEAD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iEnable,
    input  logic iPadA,
    input  logic iPadB,
    output logic oDriveA,
    output logic oDriveB,
    output logic oOwnerA,
    output logic oOwnerB,
    output logic oStuck
);
    localparam int FW = cntWidth(FILTER_CYCLES);
    localparam int TW = cntWidth(TIMEOUT_CYCLES);
    localparam int DW = cntWidth(DEAD_CYCLES);
    logic [1:0] pads, synced, filtered;
    assign pads = {iPadB, iPadA};
    for (genvar p = 0; p < 2; p++) begin : g_in
        logic [SYNC_STAGES-1:0] syncReg;
        always_ff @(posedge iCLK)
            syncReg <= iRST ? '1 : {syncReg[SYNC_STAGES-2:0], pads[p]};
        assign synced[p] = syncReg[SYNC_STAGES-1];
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign filtered[p] = synced[p];
        end else begin : g_filt
            logic [FW-1:0] runLen;
            logic level;
            // A new level is accepted only after a full run of identical samples
            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    level <= 1'b1;
                    runLen <= '0;
                end else if (synced[p] == level) begin
                    runLen <= '0;
                end else if (runLen == FW'(FILTER_CYCLES - 1)) begin
                    level <= synced[p];
                    runLen <= '0;
                end else begin
                    runLen <= runLen + FW'(1);
                end
            end
            assign filtered[p] = level;
        end
    end
    lineState_t state, nextState;
    logic [TW-1:0] timer;
    logic [DW-1:0] deadCnt;
    logic fA, fB, owned, timedOut;
    assign fA = filtered[0];
    assign fB = filtered[1];
    assign owned = (state == A_OWNS) || (state == B_OWNS);
    assign timedOut = (TIMEOUT_CYCLES != 0) && (int'(timer) == TIMEOUT_CYCLES - 1);
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = (!fA && fB) ? A_OWNS : (fA && !fB) ? B_OWNS : IDLE;
            A_OWNS:  nextState = fA ? DEAD : timedOut ? STUCK : A_OWNS;
            B_OWNS:  nextState = fB ? DEAD : timedOut ? STUCK : B_OWNS;
            DEAD:    nextState = (int'(deadCnt) == DEAD_CYCLES - 1) ? IDLE : DEAD;
            STUCK:   nextState = (fA && fB) ? DEAD : STUCK;
            default: nextState = IDLE;
        endcase
        if (!iEnable) nextState = IDLE;
    end
    // Counters restart on every state change and saturate at their limits
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
            timer <= '0;
            deadCnt <= '0;
        end else begin
            state <= nextState;
            timer <= (!iEnable || nextState != state) ? '0 :
                     (owned && timer != TW'(TIMEOUT_CYCLES)) ? timer + TW'(1) : timer;
            deadCnt <= (!iEnable || nextState != state) ? '0 :
                       (state == DEAD && deadCnt != DW'(DEAD_CYCLES)) ? deadCnt + DW'(1) : deadCnt;
        end
    end
    assign oOwnerA = state == A_OWNS;
    assign oOwnerB = state == B_OWNS;
    assign oStuck = state == STUCK;
    assign oDriveB = oOwnerA && !iRST;
    assign oDriveA = oOwnerB && !iRST;
endmodule

// File: rtl/i2c_od_bridge.sv
// i2c_od_bridge: multi-line bidirectional open-drain bridge; the first side pulled low owns the line
// and the block mirrors that low onto the opposite pad.
module i2c_od_bridge #(
    parameter int NUM_LINES      = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 3,
    parameter int DEAD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [NUM_LINES-1:0] iENABLE,
    inout  wire  [NUM_LINES-1:0] bPORT_A,
    inout  wire  [NUM_LINES-1:0] bPORT_B,
    output logic [NUM_LINES-1:0] oOWNER_A,
    output logic [NUM_LINES-1:0] oOWNER_B,
    output logic [NUM_LINES-1:0] oSTUCK
);
    logic [NUM_LINES-1:0] driveA, driveB;
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        od_line_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .DEAD_CYCLES(DEAD_CYCLES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_chan (
            .iCLK(iCLK),
            .iRST(iRST),
            .iEnable(iENABLE[i]),
            .iPadA(bPORT_A[i]),
            .iPadB(bPORT_B[i]),
            .oDriveA(driveA[i]),
            .oDriveB(driveB[i]),
            .oOwnerA(oOWNER_A[i]),
            .oOwnerB(oOWNER_B[i]),
            .oStuck(oSTUCK[i])
        );
        assign bPORT_A[i] = driveA[i] ? 1'b0 : 1'bz;
        assign bPORT_B[i] = driveB[i] ? 1'b0 : 1'bz;
    end
endmodule

// File: tb/tb_i2c_od_bridge.sv
// tb_i2c_od_bridge: scoreboard bench for the open-drain bridge; external devices pull pads low
// against pull-ups and expected per-line status/drive snapshots are queued against cycle numbers.
module tb_i2c_od_bridge;
    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    logic [1:0] iENABLE = 2'b11;
    logic [1:0] extA = 2'b00;
    logic [1:0] extB = 2'b00;
    wire  [1:0] bPORT_A, bPORT_B;
    logic [1:0] oOWNER_A, oOWNER_B, oSTUCK;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int at;
        int ln;
        logic [4:0] val;
        logic [4:0] got;
        string name;
    } exp_t;
    exp_t sb[$];
    exp_t done[$];

    localparam logic [4:0] S_IDLE = 5'b00000;
    localparam logic [4:0] S_AOWN = 5'b00110;
    localparam logic [4:0] S_BOWN = 5'b01001;
    localparam logic [4:0] S_STK  = 5'b10000;

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    i2c_od_bridge #(
        .NUM_LINES(2),
        .SYNC_STAGES(2),
        .FILTER_CYCLES(3),
        .DEAD_CYCLES(16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iENABLE(iENABLE),
        .bPORT_A(bPORT_A),
        .bPORT_B(bPORT_B),
        .oOWNER_A(oOWNER_A),
        .oOWNER_B(oOWNER_B),
        .oSTUCK(oSTUCK)
    );

    for (genvar g = 0; g < 2; g++) begin : g_pad
        assign bPORT_A[g] = extA[g] ? 1'b0 : 1'bz;
        assign bPORT_B[g] = extB[g] ? 1'b0 : 1'bz;
        pullup (bPORT_A[g]);
        pullup (bPORT_B[g]);
    end

    // Snapshot {stuck, ownerB, ownerA, DUT drives B, DUT drives A}
    function automatic logic [4:0] obs(input int ln);
        return {oSTUCK[ln], oOWNER_B[ln], oOWNER_A[ln],
                bPORT_B[ln] === 1'b0 && !extB[ln], bPORT_A[ln] === 1'b0 && !extA[ln]};
    endfunction

    task automatic expectAt(input int dt, input int ln, input logic [4:0] v, input string n);
        exp_t e;
        e.at = cyc + dt;
        e.ln = ln;
        e.val = v;
        e.got = 'x;
        e.name = n;
        sb.push_back(e);
    endtask

    // Advance n cycles, capturing outputs for every expectation that matures
    task automatic step(input int n);
        repeat (n) begin
            @(negedge iCLK);
            for (int k = sb.size() - 1; k >= 0; k--)
                if (sb[k].at == cyc) begin
                    sb[k].got = obs(sb[k].ln);
                    done.push_back(sb[k]);
                    sb.delete(k);
                end
            #1;
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        step(3);
        checks++;
        if ({oOWNER_A, oOWNER_B, oSTUCK} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: got %b, expected 000000", {oOWNER_A, oOWNER_B, oSTUCK});
        end
        checks++;
        if ({bPORT_A, bPORT_B} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_pads: got %b, expected 1111", {bPORT_A, bPORT_B});
        end
        iRST = 1'b0;
        step(3);
    endtask

    task automatic test_basic();
        exp_t e;
        extA[0] = 1'b1;
        expectAt(5, 0, S_IDLE, "basic_pre_drive");
        expectAt(6, 0, S_AOWN, "basic_a_owns");
        step(40);
        extA[0] = 1'b0;
        expectAt(5, 0, S_AOWN, "basic_hold");
        expectAt(6, 0, S_IDLE, "basic_release");
        step(6);
        extB[0] = 1'b1;
        step(4);
        extB[0] = 1'b0;
        expectAt(1, 0, S_IDLE, "basic_echo_quiet");
        expectAt(2, 0, S_IDLE, "basic_echo_quiet");
        step(2);
        extA[0] = 1'b1;
        for (int k = 1; k <= 10; k++) expectAt(k, 0, S_IDLE, "basic_dead_quiet");
        expectAt(11, 0, S_AOWN, "basic_dead_end");
        step(15);
        extA[0] = 1'b0;
        expectAt(6, 0, S_IDLE, "basic_rerelease");
        step(30);
        while (done.size() > 0) begin
            e = done.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %s line%0d cyc%0d: got %b, expected %b", e.name, e.ln, e.at, e.got, e.val);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL basic_pending: got %0d entries, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        extA[0] = 1'b1;
        for (int k = 1; k <= 10; k++) expectAt(k, 0, S_IDLE, "glitch_ignored");
        step(2);
        extA[0] = 1'b0;
        step(12);
        while (done.size() > 0) begin
            e = done.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %s line%0d cyc%0d: got %b, expected %b", e.name, e.ln, e.at, e.got, e.val);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        extA[0] = 1'b1;
        extB[0] = 1'b1;
        expectAt(6, 0, S_IDLE, "sim_both_low");
        expectAt(10, 0, S_IDLE, "sim_both_low_hold");
        step(10);
        extA[0] = 1'b0;
        expectAt(5, 0, S_IDLE, "sim_b_pre");
        expectAt(6, 0, S_BOWN, "sim_b_owns");
        step(10);
        extB[0] = 1'b0;
        expectAt(5, 0, S_BOWN, "sim_b_hold");
        expectAt(6, 0, S_IDLE, "sim_b_release");
        step(30);
        while (done.size() > 0) begin
            e = done.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %s line%0d cyc%0d: got %b, expected %b", e.name, e.ln, e.at, e.got, e.val);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        extA[0] = 1'b1;
        expectAt(6, 0, S_AOWN, "to_owned");
        expectAt(105, 0, S_AOWN, "to_last_owned");
        expectAt(106, 0, S_STK, "to_stuck");
        step(300);
        extA[0] = 1'b0;
        expectAt(5, 0, S_STK, "to_stuck_hold");
        expectAt(6, 0, S_IDLE, "to_stuck_exit");
        step(6);
        extA[0] = 1'b1;
        expectAt(16, 0, S_IDLE, "to_dead");
        expectAt(17, 0, S_AOWN, "to_idle_again");
        step(20);
        extA[0] = 1'b0;
        expectAt(6, 0, S_IDLE, "to_final_release");
        step(30);
        while (done.size() > 0) begin
            e = done.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %s line%0d cyc%0d: got %b, expected %b", e.name, e.ln, e.at, e.got, e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        extA[0] = 1'b1;
        expectAt(6, 0, S_AOWN, "rst_owned");
        step(10);
        iRST = 1'b1;
        step(1);
        checks++;
        if ({oOWNER_A, oOWNER_B, oSTUCK} !== 6'b0) begin
            errors++;
            $display("FAIL rst_status: got %b, expected 000000", {oOWNER_A, oOWNER_B, oSTUCK});
        end
        checks++;
        if (bPORT_B !== 2'b11) begin
            errors++;
            $display("FAIL rst_pad_b: got %b, expected 11", bPORT_B);
        end
        iRST = 1'b0;
        expectAt(5, 0, S_IDLE, "rst_refilter");
        expectAt(6, 0, S_AOWN, "rst_reowned");
        step(10);
        extA[0] = 1'b0;
        step(30);
        while (done.size() > 0) begin
            e = done.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %s line%0d cyc%0d: got %b, expected %b", e.name, e.ln, e.at, e.got, e.val);
            end
        end
    endtask

    task automatic test_independent();
        exp_t e;
        extA[0] = 1'b1;
        extB[1] = 1'b1;
        expectAt(6, 0, S_AOWN, "ind_l0_a");
        expectAt(6, 1, S_BOWN, "ind_l1_b");
        step(10);
        iENABLE[1] = 1'b0;
        expectAt(1, 1, S_IDLE, "ind_l1_disabled");
        expectAt(1, 0, S_AOWN, "ind_l0_kept");
        expectAt(5, 1, S_IDLE, "ind_l1_stays_off");
        step(8);
        iENABLE[1] = 1'b1;
        expectAt(1, 1, S_BOWN, "ind_l1_reenabled");
        step(4);
        extA[0] = 1'b0;
        extB[1] = 1'b0;
        expectAt(6, 0, S_IDLE, "ind_l0_release");
        expectAt(6, 1, S_IDLE, "ind_l1_release");
        step(30);
        while (done.size() > 0) begin
            e = done.pop_front();
            checks++;
            if (e.got !== e.val) begin
                errors++;
                $display("FAIL %s line%0d cyc%0d: got %b, expected %b", e.name, e.ln, e.at, e.got, e.val);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_pending: got %0d entries, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_independent();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
